// File: rtl/dac_frame_scheduler.sv
// dac_frame_scheduler
// Once per sample period, snapshots the per-channel samples loaded by the
// upstream producers and issues one MAX5134 write frame per pending, enabled
// channel (A..D in that order) to the SPI serializer. Each frame is allowed
// to finish (dac_busy low) before the next one is started.
module dac_frame_scheduler #(
   parameter int         SAMPLE_INTERVAL = 2015,
   parameter logic [3:0] CMD_WRITE_THRU  = 4'b0011,
   parameter int         MIN_GAP         = 2
) (
   input  logic        clock_in,
   input  logic        reset,
   input  logic [63:0] ch_data,
   input  logic [3:0]  ch_load,
   input  logic [3:0]  ch_enable,
   input  logic        dac_busy,
   output logic [23:0] dac_data,
   output logic        send,
   output logic        sample_tick,
   output logic        overrun,
   output logic        active
);

   localparam int TW = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL + 1) : 1;
   localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_SEND,
      ST_WAIT
   } state_t;

   logic [TW-1:0]     r_timer;
   logic              w_tick;
   logic              w_snap;
   logic [3:0]        r_pending;
   logic [3:0][15:0]  r_data_reg;
   logic [3:0][15:0]  r_shadow;
   logic [3:0]        r_send_mask;
   state_t            r_state;
   logic [GW-1:0]     r_gap;
   logic [23:0]       r_dac_data;
   logic              r_send;
   logic              r_overrun;
   logic              r_active;
   logic [1:0]        w_sel_idx;
   logic [3:0]        w_sel_onehot;

   assign w_tick = (r_timer == TW'(SAMPLE_INTERVAL));
   // A tick only starts a new period when the previous one has fully drained.
   assign w_snap = w_tick && (r_state == ST_IDLE);

   // Free-running sample-period timer; wraps on the tick cycle.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         r_timer <= '0;
      end else if (w_tick) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + 1'b1;
      end
   end

   // Latch producer samples; a load on the snapshot cycle belongs to the next period.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         r_data_reg <= '0;
         r_pending  <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (ch_load[i]) begin
               r_data_reg[i] <= ch_data[16*i +: 16];
            end
         end
         if (w_snap) begin
            r_pending <= ch_load;
         end else begin
            r_pending <= r_pending | ch_load;
         end
      end
   end

   // Lowest set bit of the remaining send mask gives fixed A..D ordering.
   always_comb begin
      w_sel_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (r_send_mask[i]) begin
            w_sel_idx = 2'(i);
         end
      end
   end

   assign w_sel_onehot = 4'b0001 << w_sel_idx;

   // Frame sequencer: snapshot, pick next channel, strobe send, wait for completion.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_shadow    <= '0;
         r_send_mask <= '0;
         r_gap       <= '0;
         r_dac_data  <= '0;
         r_send      <= 1'b0;
         r_overrun   <= 1'b0;
         r_active    <= 1'b0;
      end else begin
         r_send <= 1'b0;
         // A tick that finds the sequencer still busy is dropped and flagged.
         if (w_tick && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_tick) begin
                  r_shadow    <= r_data_reg;
                  r_send_mask <= r_pending & ch_enable;
                  r_active    <= 1'b1;
                  r_state     <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (r_send_mask == 4'b0000) begin
                  r_active <= 1'b0;
                  r_state  <= ST_IDLE;
               end else begin
                  r_dac_data  <= {CMD_WRITE_THRU, w_sel_onehot, r_shadow[w_sel_idx]};
                  r_send_mask <= r_send_mask & ~w_sel_onehot;
                  r_send      <= 1'b1;
                  r_state     <= ST_SEND;
               end
            end
            ST_SEND: begin
               r_gap   <= GW'(MIN_GAP);
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               // Busy is ignored until the serializer has had MIN_GAP cycles to raise it.
               if (r_gap != '0) begin
                  r_gap <= r_gap - 1'b1;
               end
               if ((r_gap <= GW'(1)) && !dac_busy) begin
                  r_state <= ST_SCAN;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign dac_data    = r_dac_data;
   assign send        = r_send;
   assign sample_tick = w_tick;
   assign overrun     = r_overrun;
   assign active      = r_active;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// tb_dac_frame_scheduler
// Drives randomized channel loads and a reactive serializer busy model into
// dac_frame_scheduler and compares every cycle against an event-level model:
// at each accepted tick the expected frames and their send cycles are derived
// arithmetically from the pending/enabled channels and the busy length.
`timescale 1ns/1ps
module tb_dac_frame_scheduler;

   localparam int         TB_INTERVAL = 255;
   localparam int         PERIOD      = TB_INTERVAL + 1;
   localparam logic [3:0] CMD         = 4'b0011;
   localparam int         GAP         = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] ch_data;
   logic [3:0]  ch_load;
   logic [3:0]  ch_enable;
   logic        dac_busy;
   logic [23:0] dac_data;
   logic        send;
   logic        sample_tick;
   logic        overrun;
   logic        active;

   always #5 clk = ~clk;

   dac_frame_scheduler #(
      .SAMPLE_INTERVAL (TB_INTERVAL),
      .CMD_WRITE_THRU  (CMD),
      .MIN_GAP         (GAP)
   ) dut (
      .clock_in    (clk),
      .reset       (reset),
      .ch_data     (ch_data),
      .ch_load     (ch_load),
      .ch_enable   (ch_enable),
      .dac_busy    (dac_busy),
      .dac_data    (dac_data),
      .send        (send),
      .sample_tick (sample_tick),
      .overrun     (overrun),
      .active      (active)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc;
   int          busy_len;
   int          busy_left;
   logic        plan_reset;
   logic [3:0]  plan_load;
   logic [63:0] plan_data;
   logic        prev_reset;
   logic [15:0] m_data [4];
   logic [3:0]  m_pend;
   logic        m_over;
   int          seq_end;
   int          act_start;
   int          q_cyc [$];
   logic [23:0] q_frame [$];
   logic [23:0] m_last;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic model_clear();
      cyc       = 0;
      busy_left = 0;
      for (int i = 0; i < 4; i++) m_data[i] = '0;
      m_pend    = '0;
      m_over    = 1'b0;
      seq_end   = 0;
      act_start = 0;
      q_cyc.delete();
      q_frame.delete();
      m_last    = '0;
   endtask

   // One clock cycle: drive inputs after the edge, update the model, check at negedge.
   task automatic step();
      logic exp_tick, exp_send, exp_act, exp_over, idle;
      int   c, s;
      @(posedge clk);
      #1;
      reset     = plan_reset;
      ch_load   = plan_reset ? 4'b0000 : plan_load;
      ch_data   = plan_data;
      plan_load = '0;
      plan_data = {$urandom, $urandom};
      if (plan_reset) begin
         dac_busy = 1'b0;
         @(negedge clk);
         if (prev_reset) begin
            check_val("rst_send", send, 0);
            check_val("rst_tick", sample_tick, 0);
            check_val("rst_active", active, 0);
            check_val("rst_overrun", overrun, 0);
            check_val("rst_dac_data", dac_data, 0);
         end
         prev_reset = 1'b1;
         model_clear();
      end else begin
         prev_reset = 1'b0;
         dac_busy   = (busy_left > 0);
         if (busy_left > 0) busy_left--;
         exp_tick = ((cyc % PERIOD) == PERIOD - 1);
         idle     = (cyc >= seq_end);
         exp_over = m_over;
         if (exp_tick && idle) begin
            // Frame k starts two cycles after the previous completion point;
            // completion is the first cycle at least GAP after send with busy low.
            c = cyc;
            for (int i = 0; i < 4; i++) begin
               if (m_pend[i] && ch_enable[i]) begin
                  s = c + 2;
                  q_cyc.push_back(s);
                  q_frame.push_back({CMD, 4'(1 << i), m_data[i]});
                  c = (busy_len + 1 > GAP) ? s + busy_len + 1 : s + GAP;
               end
            end
            act_start = cyc + 1;
            seq_end   = c + 2;
            m_pend    = ch_load;
         end else begin
            if (exp_tick) m_over = 1'b1;
            m_pend = m_pend | ch_load;
         end
         for (int i = 0; i < 4; i++) begin
            if (ch_load[i]) m_data[i] = ch_data[16*i +: 16];
         end
         exp_act  = (cyc >= act_start) && (cyc < seq_end);
         exp_send = (q_cyc.size() > 0) && (q_cyc[0] == cyc);
         if (exp_send) begin
            m_last = q_frame[0];
            void'(q_cyc.pop_front());
            void'(q_frame.pop_front());
         end
         @(negedge clk);
         check_val("tick", sample_tick, exp_tick);
         check_val("send", send, exp_send);
         check_val("dac_data", dac_data, m_last);
         check_val("active", active, exp_act);
         check_val("overrun", overrun, exp_over);
         if (send) begin
            busy_left = busy_len;
            $display("frame cycle=%0d data=0x%06h", cyc, dac_data);
         end
         cyc++;
      end
   endtask

   task automatic run_cycles(input int n);
      repeat (n) step();
   endtask

   // Advance until the next cycle to be stepped is a tick cycle.
   task automatic run_to_tick();
      while ((cyc % PERIOD) != PERIOD - 1) step();
   endtask

   task automatic load_ch(input int idx, input logic [15:0] val);
      plan_data[16*idx +: 16] = val;
      plan_load[idx]          = 1'b1;
      step();
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      ch_load    = '0;
      ch_data    = '0;
      ch_enable  = 4'hF;
      dac_busy   = 1'b0;
      plan_reset = 1'b1;
      plan_load  = '0;
      plan_data  = '0;
      prev_reset = 1'b0;
      busy_len   = 0;
      model_clear();
      run_cycles(3);
      plan_reset = 1'b0;

      // Single channel A, short busy; following period has nothing pending.
      busy_len = 5;
      run_cycles($urandom_range(5, 100));
      load_ch(0, 16'h1234);
      run_to_tick(); step();
      run_to_tick(); step();
      run_to_tick();

      // A, C, D with a 40-cycle busy; B never loaded.
      busy_len = 40;
      step();
      run_cycles($urandom_range(1, 50)); load_ch(0, 16'h0001);
      run_cycles($urandom_range(1, 50)); load_ch(2, 16'h00CC);
      run_cycles($urandom_range(1, 50)); load_ch(3, 16'hFFFF);
      run_to_tick(); step();
      run_to_tick();

      // B masked off while all four are pending, then an empty period.
      busy_len  = $urandom_range(0, 10);
      ch_enable = 4'b1101;
      step();
      for (int i = 0; i < 4; i++) begin
         run_cycles($urandom_range(1, 40));
         load_ch(i, 16'($urandom));
      end
      run_to_tick(); step();
      run_to_tick();
      ch_enable = 4'hF;
      step();
      run_to_tick();

      // B loaded on the tick cycle itself is deferred to the next period.
      busy_len = 10;
      step();
      run_cycles($urandom_range(1, 100));
      load_ch(0, 16'($urandom));
      run_to_tick();
      load_ch(1, 16'hBEEF);
      run_to_tick(); step();
      run_to_tick();

      // Randomized periods: random loads, enables and busy lengths.
      for (int p = 0; p < 6; p++) begin
         busy_len  = $urandom_range(0, 30);
         ch_enable = 4'($urandom_range(0, 15));
         step();
         for (int k = 0; k < int'($urandom_range(0, 5)); k++) begin
            run_cycles($urandom_range(1, 40));
            plan_load = 4'($urandom_range(0, 15));
            step();
         end
         run_to_tick(); step();
         run_to_tick();
      end

      // Long busy with four frames: second tick is dropped and overrun sticks.
      busy_len  = 100;
      ch_enable = 4'hF;
      step();
      for (int i = 0; i < 4; i++) load_ch(i, 16'($urandom));
      run_to_tick(); step();
      run_to_tick(); step();
      run_to_tick(); step();
      run_cycles(20);

      // Reset clears overrun; then reset again mid-sequence with two frames queued.
      plan_reset = 1'b1;
      run_cycles(2);
      plan_reset = 1'b0;
      busy_len = 30;
      step();
      load_ch(0, 16'($urandom));
      load_ch(1, 16'($urandom));
      load_ch(3, 16'($urandom));
      run_to_tick(); step();
      for (int k = 0; k < PERIOD && q_cyc.size() > 2; k++) step();
      run_cycles(5);
      plan_reset = 1'b1;
      step();
      plan_reset = 1'b0;
      run_to_tick(); step();
      run_cycles(10);
      load_ch(2, 16'($urandom));
      run_to_tick(); step();
      run_to_tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
